icache: RTL and testbench

Direct-mapped, blocking instruction cache between the fetch stage and the IF/ID register. It takes the fetch PC and request each cycle and returns the 32-bit instruction one cycle later on a hit. On a miss it raises a stall toward the flow controller and refills the whole line from the instruction memory port with a small FSM. The flow controller then issues back-and-keep, and fetch re-presents the missed PC.

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_line_ram.sv | 23 ++
 rtl/icache.sv | 135 +++++++++++++
 tb/tb_icache.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared FSM state type and derived address-field widths for the instruction cache
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_REFILL    = 2'd2,
    ST_FILL_DONE = 2'd3
  } icache_state_e;

  // word-select bits inside a line
  function automatic int wb_bits(input int words);
    return $clog2(words);
  endfunction

  // line-index bits
  function automatic int ib_bits(input int lines);
    return $clog2(lines);
  endfunction

  // tag bits: whatever is left of the 30-bit word address
  function automatic int tb_bits(input int lines, input int words);
    return 30 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// rtl/icache_line_ram.sv - instruction data array, one synchronous write port and one asynchronous read port
module icache_line_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // refill beats land here; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped blocking instruction cache with whole-line refill FSM
module icache
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc_i,
  input  logic        if_req_i,
  input  logic        if_jump_i,
  input  logic        fc_flush_i,
  output logic [31:0] icache_inst_o,
  output logic        icache_valid_o,
  output logic [31:0] icache_pc_o,
  output logic        icache_miss_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int WB = wb_bits(WORDS);
  localparam int IB = ib_bits(LINES);
  localparam int TB = tb_bits(LINES, WORDS);

  logic [WB-1:0]    pc_word;
  logic [IB-1:0]    pc_idx;
  logic [TB-1:0]    pc_tag;
  logic [TB+IB-1:0] miss_line;
  logic [IB-1:0]    miss_idx;
  logic [TB-1:0]    miss_tag;

  icache_state_e    state;
  logic [WB-1:0]    beat;
  logic [LINES-1:0] valid_bits;
  logic             flush_seen;
  logic [TB-1:0]    tag_arr [LINES];

  logic [31:0]      rd_data;
  logic             fill_we;
  logic             fill_last;
  logic             hit;
  logic             unused_inputs;

  assign pc_word  = if_pc_i[2 +: WB];
  assign pc_idx   = if_pc_i[2+WB +: IB];
  assign pc_tag   = if_pc_i[2+WB+IB +: TB];
  assign miss_idx = miss_line[IB-1:0];
  assign miss_tag = miss_line[IB +: TB];

  // beats only count in REFILL; a reset in the same cycle drops the beat
  assign fill_we   = (state == ST_REFILL) && mem_rvalid_i && !rst;
  assign fill_last = fill_we && (beat == WB'(WORDS - 1));

  // a flush in the lookup cycle forces a miss so fence.i is never bypassed
  assign hit = valid_bits[pc_idx] && (tag_arr[pc_idx] == pc_tag) && !fc_flush_i;

  assign mem_req_o     = (state == ST_MISS_REQ);
  assign icache_miss_o = (state != ST_IDLE);
  assign mem_addr_o    = {miss_line, {(WB+2){1'b0}}};

  // the jump hint is for the flow controller only; byte offset is ignored
  assign unused_inputs = ^{if_jump_i, if_pc_i[1:0]};

  icache_line_ram #(
    .DEPTH (LINES * WORDS),
    .AW    (IB + WB)
  ) u_line_ram (
    .clk   (clk),
    .we    (fill_we),
    .waddr ({miss_idx, beat}),
    .wdata (mem_rdata_i),
    .raddr ({pc_idx, pc_word}),
    .rdata (rd_data)
  );

  // tag written with the last beat; not reset because valid bits gate it
  always_ff @(posedge clk) begin
    if (fill_last) tag_arr[miss_idx] <= miss_tag;
  end

  // lookup, miss FSM, valid bits and registered fetch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      beat           <= '0;
      valid_bits     <= '0;
      flush_seen     <= 1'b0;
      miss_line      <= '0;
      icache_inst_o  <= '0;
      icache_valid_o <= 1'b0;
      icache_pc_o    <= '0;
    end else begin
      icache_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          flush_seen <= 1'b0;
          if (if_req_i) begin
            if (hit) begin
              icache_inst_o  <= rd_data;
              icache_valid_o <= 1'b1;
              icache_pc_o    <= if_pc_i;
            end else begin
              miss_line <= if_pc_i[31:2+WB];
              beat      <= '0;
              state     <= ST_MISS_REQ;
            end
          end
        end
        ST_MISS_REQ: begin
          if (mem_gnt_i) state <= ST_REFILL;
        end
        ST_REFILL: begin
          if (fill_we) begin
            beat <= beat + 1'b1;
            if (fill_last) begin
              if (!flush_seen) valid_bits[miss_idx] <= 1'b1;
              state <= ST_FILL_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      // flush wins over a same-cycle line validation; remembered until IDLE
      if (fc_flush_i) begin
        valid_bits <= '0;
        if (state != ST_IDLE) flush_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache with directed steps and a randomized phase
module tb_icache;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int LB    = WORDS * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_req = 1'b0;
  logic        if_jump = 1'b0;
  logic        fc_flush = 1'b0;
  logic [31:0] inst;
  logic        valid;
  logic [31:0] pc_out;
  logic        miss;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  // reference: index -> resident line address, and word address -> last data memory returned
  logic [31:0] cached  [int];
  logic [31:0] word_of [int unsigned];

  icache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc_i        (if_pc),
    .if_req_i       (if_req),
    .if_jump_i      (if_jump),
    .fc_flush_i     (fc_flush),
    .icache_inst_o  (inst),
    .icache_valid_o (valid),
    .icache_pc_o    (pc_out),
    .icache_miss_o  (miss),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inst"}, inst, 32'h0);
    chk1({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk1({tag, "_miss"}, miss, 1'b0);
    chk1({tag, "_mreq"}, mem_req, 1'b0);
    chk({tag, "_maddr"}, mem_addr, 32'h0);
  endtask

  // one fetch request in IDLE; leaves if_req high so calls can run back-to-back
  task automatic lookup(input logic [31:0] pc, input bit flush, output bit missed);
    logic [31:0] line;
    int idx;
    line = pc & ~32'(LB - 1);
    idx  = int'((pc / LB) % LINES);
    missed = flush || !(cached.exists(idx) && cached[idx] == line);
    if_pc = pc; if_req = 1'b1; if_jump = 1'($urandom); fc_flush = flush;
    tick();
    fc_flush = 1'b0;
    if (flush) cached.delete();
    if (!missed) begin
      chk1("hit_valid", valid, 1'b1);
      chk("hit_inst", inst, word_of[pc >> 2]);
      chk("hit_pc", pc_out, pc);
      chk1("hit_nomiss", miss, 1'b0);
    end else begin
      chk1("miss_valid", valid, 1'b0);
      chk1("miss_flag", miss, 1'b1);
      chk1("miss_mreq", mem_req, 1'b1);
      chk("miss_maddr", mem_addr, line);
    end
  endtask

  // plays the memory side of one line refill, optionally flushing or resetting mid-way
  task automatic refill(input logic [31:0] line, input int gnt_wait, input int flush_beat,
                        input int rst_beat, input bit fixed, input logic [31:0] base);
    logic [31:0] d;
    bit flushed;
    int idx;
    idx = int'((line / LB) % LINES);
    flushed = 1'b0;
    for (int i = 0; i < gnt_wait; i++) begin
      if_req = 1'($urandom); if_pc = $urandom;
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      tick();
      chk1("stall_mreq", mem_req, 1'b1);
      chk("stall_maddr", mem_addr, line);
      chk1("stall_miss", miss, 1'b1);
      chk1("stall_valid", valid, 1'b0);
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk1("gnt_mreq", mem_req, 1'b0);
    chk1("gnt_miss", miss, 1'b1);
    for (int b = 0; b < WORDS; b++) begin
      repeat ($urandom_range(0, 2)) begin
        if_req = 1'($urandom); if_pc = $urandom;
        tick();
        chk1("gap_miss", miss, 1'b1);
        chk1("gap_valid", valid, 1'b0);
      end
      d = fixed ? base + 32'(b) : $urandom;
      mem_rvalid = 1'b1; mem_rdata = d; fc_flush = (b == flush_beat);
      tick();
      mem_rvalid = 1'b0;
      chk1("beat_miss", miss, 1'b1);
      if (fc_flush) begin
        flushed = 1'b1;
        cached.delete();
      end
      fc_flush = 1'b0;
      word_of[(line >> 2) + 32'(b)] = d;
      if (b == rst_beat) begin
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
        tick();
        rst = 1'b0; mem_rvalid = 1'b0;
        cached.delete();
        chk_all_zero("midrst");
        return;
      end
    end
    chk1("fill_mreq", mem_req, 1'b0);
    chk1("fill_valid", valid, 1'b0);
    // a request presented during FILL_DONE must be dropped
    if_req = 1'b1; if_pc = line;
    tick();
    if_req = 1'b0;
    chk1("done_miss", miss, 1'b0);
    chk1("done_valid", valid, 1'b0);
    if (!flushed) cached[idx] = line;
  endtask

  task automatic access(input logic [31:0] pc, input bit flush, input int gnt_wait,
                        input int flush_beat, input int rst_beat);
    bit m;
    lookup(pc, flush, m);
    if (m) refill(pc & ~32'(LB - 1), gnt_wait, flush_beat, rst_beat, 1'b0, 32'h0);
  endtask

  initial begin
    bit m;
    logic [31:0] rpc;

    // reset values
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // cold miss on 0x100, fill with 0xA0..0xA3, then four back-to-back hits
    lookup(32'h100, 1'b0, m);
    refill(32'h100, 1, -1, -1, 1'b1, 32'hA0);
    lookup(32'h100, 1'b0, m);
    lookup(32'h104, 1'b0, m);
    lookup(32'h108, 1'b0, m);
    lookup(32'h10C, 1'b0, m);
    chk("cold_last_inst", inst, 32'hA3);
    if_req = 1'b0;
    tick();
    chk1("idle_valid", valid, 1'b0);
    chk("idle_inst_hold", inst, 32'hA3);
    chk("idle_pc_hold", pc_out, 32'h10C);

    // misaligned PC returns the enclosing word
    lookup(32'h102, 1'b0, m);
    chk("misaligned_inst", inst, 32'hA0);

    // conflict on index 0 with a 5-cycle grant stall
    access(32'h200, 1'b0, 5, -1, -1);
    access(32'h204, 1'b0, 0, -1, -1);
    lookup(32'h100, 1'b0, m);
    refill(32'h100, 0, -1, -1, 1'b1, 32'hA0);
    lookup(32'h10C, 1'b0, m);

    // flush during the 0x300 refill invalidates it and every other line
    access(32'h140, 1'b0, 1, -1, -1);
    access(32'h140, 1'b0, 1, -1, -1);
    access(32'h300, 1'b0, 2, 2, -1);
    access(32'h300, 1'b0, 0, -1, -1);
    access(32'h140, 1'b0, 0, -1, -1);
    access(32'h300, 1'b0, 0, -1, -1);

    // flush in the lookup cycle forces a miss on a resident line
    access(32'h304, 1'b1, 1, -1, -1);
    access(32'h304, 1'b0, 1, -1, -1);

    // reset after beat 1, stray beats afterwards are ignored
    access(32'h100, 1'b0, 1, -1, 1);
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      tick();
      chk1("stray_miss", miss, 1'b0);
      chk1("stray_mreq", mem_req, 1'b0);
      chk1("stray_valid", valid, 1'b0);
    end
    mem_rvalid = 1'b0;
    access(32'h100, 1'b0, 1, -1, -1);
    access(32'h100, 1'b0, 1, -1, -1);

    // randomized traffic over a small, collision-heavy address pool
    for (int it = 0; it < 80; it++) begin
      rpc = $urandom & 32'hF000_03FF;
      access(rpc, ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1, -1);
      if ($urandom_range(0, 3) == 0) begin
        if_req = 1'b0;
        tick();
        chk1("rand_idle_valid", valid, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
